// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: debounces keypad presses and runs axis/value command entry
// with a valid/ready handoff of committed commands to the motion core.
module keypad_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_code,
  input  logic        key_released,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [1:0]  cmd_axis,
  output logic [15:0] cmd_value,
  output logic [1:0]  axis_sel,
  output logic        axis_active,
  output logic [15:0] entry_value,
  output logic [2:0]  entry_digits,
  output logic        key_err
);
  typedef enum logic [1:0] {IDLE, ENTRY, SEND} state_t;
  localparam logic [19:0] CNT_MAX = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] DIG_MAX = 3'(MAX_DIGITS);
  state_t state, state_n;
  logic rel_q, level, press_evt;
  logic [19:0] cnt;
  logic [3:0] code, off;
  logic is_digit, is_axis, is_clr;
  logic cmd_valid_n, axis_active_n, key_err_n;
  logic [1:0] cmd_axis_n, axis_sel_n;
  logic [15:0] cmd_value_n, entry_value_n;
  logic [2:0] entry_digits_n;
  // The key code is latched on the debounced press edge, so later scanner
  // changes while the key is held cannot alter the event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_q <= 1'b1;
      level <= 1'b1;
      cnt <= '0;
      press_evt <= 1'b0;
      code <= '0;
    end else begin
      rel_q <= key_released;
      press_evt <= 1'b0;
      if (rel_q == level) cnt <= '0;
      else if (cnt == CNT_MAX) begin
        cnt <= '0;
        level <= rel_q;
        press_evt <= !rel_q;
        if (!rel_q) code <= key_code;
      end else cnt <= cnt + 20'd1;
    end
  end
  assign off = code - 4'hA;
  assign is_digit = code <= 4'd9;
  assign is_axis = code >= 4'hA && code <= 4'hD;
  assign is_clr = code == 4'hE;
  always_comb begin
    state_n = state;
    cmd_valid_n = cmd_valid;
    cmd_axis_n = cmd_axis;
    cmd_value_n = cmd_value;
    axis_sel_n = axis_sel;
    axis_active_n = axis_active;
    entry_value_n = entry_value;
    entry_digits_n = entry_digits;
    key_err_n = 1'b0;
    case (state)
      IDLE: if (press_evt) begin
        if (is_axis) begin
          axis_sel_n = off[1:0];
          axis_active_n = 1'b1;
          entry_value_n = '0;
          entry_digits_n = '0;
          state_n = ENTRY;
        end else if (!is_clr) key_err_n = 1'b1;
      end
      ENTRY: if (press_evt) begin
        if (is_digit) begin
          if (entry_digits < DIG_MAX) begin
            entry_value_n = entry_value * 16'd10 + {12'd0, code};
            entry_digits_n = entry_digits + 3'd1;
          end else key_err_n = 1'b1;
        end else if (is_axis) begin
          axis_sel_n = off[1:0];
          entry_value_n = '0;
          entry_digits_n = '0;
        end else if (entry_digits == 3'd0) begin
          if (is_clr) begin
            axis_active_n = 1'b0;
            state_n = IDLE;
          end else key_err_n = 1'b1;
        end else if (is_clr) begin
          entry_value_n = '0;
          entry_digits_n = '0;
        end else begin
          cmd_valid_n = 1'b1;
          cmd_axis_n = axis_sel;
          cmd_value_n = entry_value;
          state_n = SEND;
        end
      end
      SEND: begin
        key_err_n = press_evt;
        if (cmd_ready) begin
          cmd_valid_n = 1'b0;
          entry_value_n = '0;
          entry_digits_n = '0;
          axis_active_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cmd_valid <= 1'b0;
      cmd_axis <= '0;
      cmd_value <= '0;
      axis_sel <= '0;
      axis_active <= 1'b0;
      entry_value <= '0;
      entry_digits <= '0;
      key_err <= 1'b0;
    end else begin
      state <= state_n;
      cmd_valid <= cmd_valid_n;
      cmd_axis <= cmd_axis_n;
      cmd_value <= cmd_value_n;
      axis_sel <= axis_sel_n;
      axis_active <= axis_active_n;
      entry_value <= entry_value_n;
      entry_digits <= entry_digits_n;
      key_err <= key_err_n;
    end
  end
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: table-driven press sequences plus hand-written
// glitch and mid-transfer reset cases for keypad_entry_ctrl.
module tb_keypad_entry_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] key_code = '0;
  logic key_released = 1'b1;
  logic cmd_ready = 1'b0;
  logic cmd_valid, axis_active, key_err;
  logic [1:0] cmd_axis, axis_sel;
  logic [15:0] cmd_value, entry_value;
  logic [2:0] entry_digits;
  int tests = 0, fails = 0;
  int errs = 0, acc = 0, vcyc = 0, dbl = 0;
  logic prev_err = 1'b0;
  logic [1:0] last_axis = '0;
  logic [15:0] last_value = '0;

  keypad_entry_ctrl #(.DEBOUNCE_CYCLES(4), .MAX_DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_released(key_released),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_axis(cmd_axis),
    .cmd_value(cmd_value), .axis_sel(axis_sel), .axis_active(axis_active),
    .entry_value(entry_value), .entry_digits(entry_digits), .key_err(key_err)
  );

  always #5 clk = ~clk;

  // Handshakes and error pulses are observed on the edge where the DUT samples them.
  always @(posedge clk) if (rst_n) begin
    if (key_err) errs++;
    if (key_err && prev_err) dbl++;
    prev_err = key_err;
    if (cmd_valid) vcyc++;
    if (cmd_valid && cmd_ready) begin
      acc++;
      last_axis = cmd_axis;
      last_value = cmd_value;
    end
  end

  typedef struct {
    logic [3:0] code; int hold; logic rdy;
    logic act; logic [1:0] sel; logic [15:0] val; logic [2:0] dig;
    int err; int acc; logic valid; logic [1:0] cax; logic [15:0] cval;
  } vec_t;
  vec_t v[$];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic press(input logic [3:0] c, input int h);
    key_code = c;
    key_released = 1'b0;
    repeat (h) @(negedge clk);
    key_released = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    // code hold rdy | act sel val dig | err acc valid cax cval
    v.push_back(vec_t'{4'hA, 8, 1'b1, 1'b1, 2'd0, 16'd0, 3'd0, 0, 0, 1'b0, 2'd0, 16'd0});
    v.push_back(vec_t'{4'h1, 8, 1'b1, 1'b1, 2'd0, 16'd1, 3'd1, 0, 0, 1'b0, 2'd0, 16'd0});
    v.push_back(vec_t'{4'h2, 8, 1'b1, 1'b1, 2'd0, 16'd12, 3'd2, 0, 0, 1'b0, 2'd0, 16'd0});
    v.push_back(vec_t'{4'h3, 8, 1'b1, 1'b1, 2'd0, 16'd123, 3'd3, 0, 0, 1'b0, 2'd0, 16'd0});
    v.push_back(vec_t'{4'hF, 8, 1'b1, 1'b0, 2'd0, 16'd0, 3'd0, 0, 1, 1'b0, 2'd0, 16'd123});
    v.push_back(vec_t'{4'hC, 8, 1'b0, 1'b1, 2'd2, 16'd0, 3'd0, 0, 0, 1'b0, 2'd0, 16'd0});
    v.push_back(vec_t'{4'h9, 8, 1'b0, 1'b1, 2'd2, 16'd9, 3'd1, 0, 0, 1'b0, 2'd0, 16'd0});
    v.push_back(vec_t'{4'h9, 8, 1'b0, 1'b1, 2'd2, 16'd99, 3'd2, 0, 0, 1'b0, 2'd0, 16'd0});
    v.push_back(vec_t'{4'h9, 8, 1'b0, 1'b1, 2'd2, 16'd999, 3'd3, 0, 0, 1'b0, 2'd0, 16'd0});
    v.push_back(vec_t'{4'h9, 8, 1'b0, 1'b1, 2'd2, 16'd9999, 3'd4, 0, 0, 1'b0, 2'd0, 16'd0});
    v.push_back(vec_t'{4'h5, 8, 1'b0, 1'b1, 2'd2, 16'd9999, 3'd4, 1, 0, 1'b0, 2'd0, 16'd0});
    v.push_back(vec_t'{4'hF, 8, 1'b0, 1'b1, 2'd2, 16'd9999, 3'd4, 0, 0, 1'b1, 2'd2, 16'd9999});
    v.push_back(vec_t'{4'h7, 8, 1'b0, 1'b1, 2'd2, 16'd9999, 3'd4, 1, 0, 1'b1, 2'd2, 16'd9999});
    v.push_back(vec_t'{4'hE, 8, 1'b0, 1'b1, 2'd2, 16'd9999, 3'd4, 1, 0, 1'b1, 2'd2, 16'd9999});
    v.push_back(vec_t'{4'h0, 0, 1'b1, 1'b0, 2'd2, 16'd0, 3'd0, 0, 1, 1'b0, 2'd2, 16'd9999});
    v.push_back(vec_t'{4'hB, 8, 1'b0, 1'b1, 2'd1, 16'd0, 3'd0, 0, 0, 1'b0, 2'd0, 16'd0});
    v.push_back(vec_t'{4'h4, 8, 1'b0, 1'b1, 2'd1, 16'd4, 3'd1, 0, 0, 1'b0, 2'd0, 16'd0});
    v.push_back(vec_t'{4'h2, 8, 1'b0, 1'b1, 2'd1, 16'd42, 3'd2, 0, 0, 1'b0, 2'd0, 16'd0});
    v.push_back(vec_t'{4'hE, 8, 1'b0, 1'b1, 2'd1, 16'd0, 3'd0, 0, 0, 1'b0, 2'd0, 16'd0});
    v.push_back(vec_t'{4'hE, 8, 1'b0, 1'b0, 2'd1, 16'd0, 3'd0, 0, 0, 1'b0, 2'd0, 16'd0});
    v.push_back(vec_t'{4'hF, 8, 1'b0, 1'b0, 2'd1, 16'd0, 3'd0, 1, 0, 1'b0, 2'd0, 16'd0});
    v.push_back(vec_t'{4'hE, 8, 1'b1, 1'b0, 2'd1, 16'd0, 3'd0, 0, 0, 1'b0, 2'd0, 16'd0});
    v.push_back(vec_t'{4'hB, 8, 1'b0, 1'b1, 2'd1, 16'd0, 3'd0, 0, 0, 1'b0, 2'd0, 16'd0});
    v.push_back(vec_t'{4'h5, 50, 1'b0, 1'b1, 2'd1, 16'd5, 3'd1, 0, 0, 1'b0, 2'd0, 16'd0});
    v.push_back(vec_t'{4'hD, 8, 1'b0, 1'b1, 2'd3, 16'd0, 3'd0, 0, 0, 1'b0, 2'd0, 16'd0});
    v.push_back(vec_t'{4'h0, 8, 1'b0, 1'b1, 2'd3, 16'd0, 3'd1, 0, 0, 1'b0, 2'd0, 16'd0});
    v.push_back(vec_t'{4'hF, 8, 1'b1, 1'b0, 2'd3, 16'd0, 3'd0, 0, 1, 1'b0, 2'd3, 16'd0});

    repeat (3) @(negedge clk);
    chk("reset cmd", {cmd_valid, cmd_axis, cmd_value, key_err}, 0);
    chk("reset entry", {axis_sel, axis_active, entry_value, entry_digits}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    key_code = 4'hA;
    repeat (6) begin
      key_released = 1'b0;
      repeat (3) @(negedge clk);
      key_released = 1'b1;
      repeat (3) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    chk("glitch active", {31'd0, axis_active}, 0);
    chk("glitch errs", errs, 0);
    chk("glitch level", {31'd0, dut.level}, 1);

    for (int i = 0; i < v.size(); i++) begin
      automatic int e0 = errs, a0 = acc, c0 = vcyc;
      cmd_ready = v[i].rdy;
      press(v[i].code, v[i].hold);
      chk($sformatf("v%0d active", i), {31'd0, axis_active}, {31'd0, v[i].act});
      chk($sformatf("v%0d sel", i), {30'd0, axis_sel}, {30'd0, v[i].sel});
      chk($sformatf("v%0d value", i), {16'd0, entry_value}, {16'd0, v[i].val});
      chk($sformatf("v%0d digits", i), {29'd0, entry_digits}, {29'd0, v[i].dig});
      chk($sformatf("v%0d key_err", i), errs - e0, v[i].err);
      chk($sformatf("v%0d accepts", i), acc - a0, v[i].acc);
      chk($sformatf("v%0d cmd_valid", i), {31'd0, cmd_valid}, {31'd0, v[i].valid});
      if (v[i].acc > 0) begin
        chk($sformatf("v%0d sent axis", i), {30'd0, last_axis}, {30'd0, v[i].cax});
        chk($sformatf("v%0d sent value", i), {16'd0, last_value}, {16'd0, v[i].cval});
        chk($sformatf("v%0d valid cycles", i), vcyc - c0, 1);
      end
      if (v[i].valid) begin
        chk($sformatf("v%0d cmd_axis", i), {30'd0, cmd_axis}, {30'd0, v[i].cax});
        chk($sformatf("v%0d cmd_value", i), {16'd0, cmd_value}, {16'd0, v[i].cval});
      end
    end

    cmd_ready = 1'b0;
    press(4'hA, 8);
    press(4'h1, 8);
    press(4'hF, 8);
    chk("pre-reset valid", {31'd0, cmd_valid}, 1);
    chk("pre-reset value", {16'd0, cmd_value}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst cmd", {cmd_valid, cmd_axis, cmd_value, key_err}, 0);
    chk("async rst entry", {axis_sel, axis_active, entry_value, entry_digits}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst level", {31'd0, dut.level}, 1);
    chk("post-rst valid", {31'd0, cmd_valid}, 0);
    press(4'hB, 8);
    chk("post-rst entry", {29'd0, axis_active, axis_sel}, 3'b101);
    chk("key_err width", dbl, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
